// File: rtl/piano_pkg.sv
// Shared definitions for the piano audio path: FSM state encoding and
// saturating helpers used by the PWM DAC ramp.
package piano_pkg;

    localparam int PIANO_W = 8;

    function automatic int unsigned pwm_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    localparam int unsigned PWM_MAX = pwm_max(PIANO_W);

    typedef logic [1:0] state_t;

    localparam state_t ST_OFF       = 2'd0;
    localparam state_t ST_RAMP_UP   = 2'd1;
    localparam state_t ST_RUN       = 2'd2;
    localparam state_t ST_RAMP_DOWN = 2'd3;

    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                            input int unsigned max);
        int unsigned sum;
        sum = a + b;
        return (sum > max) ? max : sum;
    endfunction

    function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/piano_tick_gen.sv
// Prescaler: pulses tick_o once every PRESCALE clocks (every clock when PRESCALE=1).
module piano_tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    assign tick_o = (pre_q == LAST);
    assign pre_d  = tick_o ? '0 : pre_q + PW'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/piano_pwm_dac.sv
// Piano PWM output stage: period-aligned duty loading with a fade-in/fade-out
// gain ramp so enable changes and sample updates never glitch the pin.
module piano_pwm_dac
    import piano_pkg::*;
#(
    parameter int WIDTH     = PIANO_W,
    parameter int PRESCALE  = 1,
    parameter int RAMP_STEP = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sample,
    input  logic             enable,
    output logic             pwm_out,
    output logic             period_start,
    output logic             active
);

    localparam int unsigned MAX = pwm_max(WIDTH);
    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MAX);

    logic             tick;
    logic             boundary;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] ramp_q, ramp_d;
    logic [WIDTH-1:0] ramp_up, ramp_dn;
    state_t           state_q, state_d;
    logic             pwm_q, start_q, active_q;

    piano_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk_i  (clk),
        .rst_i  (rst),
        .tick_o (tick)
    );

    assign boundary = tick && (cnt_q == CNT_MAX);
    assign cnt_d    = tick ? cnt_q + WIDTH'(1) : cnt_q;
    assign ramp_up  = WIDTH'(sat_add(32'(ramp_q), RAMP_STEP, MAX));
    assign ramp_dn  = WIDTH'(sat_sub(32'(ramp_q), RAMP_STEP));

    // Ramp, state and duty only move on the last tick of a period.
    always_comb begin
        state_d = state_q;
        ramp_d  = ramp_q;
        duty_d  = duty_q;
        if (boundary) begin
            case (state_q)
                ST_OFF: begin
                    ramp_d = '0;
                    if (enable) state_d = ST_RAMP_UP;
                end
                ST_RAMP_UP: begin
                    if (!enable) begin
                        state_d = ST_RAMP_DOWN;
                        ramp_d  = ramp_dn;
                    end else begin
                        ramp_d = ramp_up;
                        if (ramp_up == CNT_MAX) state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state_d = ST_RAMP_DOWN;
                        ramp_d  = ramp_dn;
                    end else begin
                        ramp_d = CNT_MAX;
                    end
                end
                default: begin
                    if (enable) begin
                        state_d = ST_RAMP_UP;
                        ramp_d  = ramp_up;
                    end else begin
                        ramp_d = ramp_dn;
                        if (ramp_dn == '0) state_d = ST_OFF;
                    end
                end
            endcase
            duty_d = (sample < ramp_d) ? sample : ramp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            duty_q   <= '0;
            ramp_q   <= '0;
            state_q  <= ST_OFF;
            pwm_q    <= 1'b0;
            start_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            duty_q   <= duty_d;
            ramp_q   <= ramp_d;
            state_q  <= state_d;
            pwm_q    <= (cnt_q < duty_q);
            start_q  <= boundary;
            active_q <= (state_d != ST_OFF);
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = start_q;
    assign active       = active_q;

endmodule
